register_file_byte_enable: RTL and testbench



---
 rtl/register_file_byte_enable.sv | 94 +++++++++
 tb/tb_register_file_byte_enable.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/register_file_byte_enable.sv
// Multi-port register file with per-byte write strobes, highest-port-wins byte merge,
// optional same-edge write forwarding to reads, and write-conflict flag/counter.
module register_file_byte_enable #(
   parameter  int N_BIT_DATA    = 16,
   parameter  int N_BIT_ADDRESS = 5,
   parameter  int N_WRITE       = 4,
   parameter  int N_READ        = 8,
   parameter  int BYPASS        = 1,
   localparam int N_BYTE        = N_BIT_DATA / 8
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     write           [N_WRITE],
   input  logic [N_BYTE-1:0]        write_strobe    [N_WRITE],
   input  logic [N_BIT_ADDRESS-1:0] address_write   [N_WRITE],
   input  logic [N_BIT_DATA-1:0]    data_in         [N_WRITE],
   input  logic                     read            [N_READ],
   input  logic [N_BIT_ADDRESS-1:0] address_read    [N_READ],
   output logic [N_BIT_DATA-1:0]    data_out        [N_READ],
   output logic                     read_valid      [N_READ],
   output logic                     collision,
   output logic [15:0]              collision_count
);

   localparam int DEPTH = 2 ** N_BIT_ADDRESS;

   logic [N_BIT_DATA-1:0] mem_q      [DEPTH];
   logic [N_BIT_DATA-1:0] mem_d      [DEPTH];
   logic [N_BIT_DATA-1:0] data_out_q [N_READ];
   logic [N_BIT_DATA-1:0] data_out_d [N_READ];
   logic                  read_valid_q [N_READ];
   logic                  collision_q;
   logic                  collision_d;
   logic [15:0]           count_q;
   logic [15:0]           count_d;

   // Ascending port order lets the highest-index port overwrite each byte last.
   always_comb begin
      mem_d = mem_q;
      for (int i = 0; i < N_WRITE; i++) begin
         if (write[i]) begin
            for (int b = 0; b < N_BYTE; b++) begin
               if (write_strobe[i][b]) begin
                  mem_d[address_write[i]][8*b +: 8] = data_in[i][8*b +: 8];
               end
            end
         end
      end
   end

   always_comb begin
      collision_d = 1'b0;
      for (int i = 0; i < N_WRITE; i++) begin
         for (int j = i + 1; j < N_WRITE; j++) begin
            if (write[i] && write[j] && (address_write[i] == address_write[j]) &&
                (|(write_strobe[i] & write_strobe[j]))) begin
               collision_d = 1'b1;
            end
         end
      end
      count_d = (collision_d && (count_q != 16'hFFFF)) ? count_q + 16'd1 : count_q;
   end

   always_comb begin
      for (int j = 0; j < N_READ; j++) begin
         data_out_d[j] = data_out_q[j];
         if (read[j]) begin
            data_out_d[j] = (BYPASS != 0) ? mem_d[address_read[j]] : mem_q[address_read[j]];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         mem_q        <= '{default: '0};
         data_out_q   <= '{default: '0};
         read_valid_q <= '{default: 1'b0};
         collision_q  <= 1'b0;
         count_q      <= 16'd0;
      end else begin
         mem_q        <= mem_d;
         data_out_q   <= data_out_d;
         read_valid_q <= read;
         collision_q  <= collision_d;
         count_q      <= count_d;
      end
   end

   assign data_out        = data_out_q;
   assign read_valid      = read_valid_q;
   assign collision       = collision_q;
   assign collision_count = count_q;

endmodule

// File: tb/tb_register_file_byte_enable.sv
// Directed bench for register_file_byte_enable: two instances share stimulus,
// one forwarding same-edge writes (BYPASS=1) and one returning pre-write data.
module tb_register_file_byte_enable;

   localparam int NW = 4;
   localparam int NR = 8;

   logic        clock = 1'b0;
   logic        reset;
   logic        write         [NW];
   logic [1:0]  write_strobe  [NW];
   logic [4:0]  address_write [NW];
   logic [15:0] data_in       [NW];
   logic        read          [NR];
   logic [4:0]  address_read  [NR];

   logic [15:0] dout_b   [NR];
   logic        rvld_b   [NR];
   logic        coll_b;
   logic [15:0] cnt_b;
   logic [15:0] dout_n   [NR];
   logic        rvld_n   [NR];
   logic        coll_n;
   logic [15:0] cnt_n;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clock = ~clock;

   register_file_byte_enable #(.BYPASS(1)) dut_b (
      .clock(clock), .reset(reset), .write(write), .write_strobe(write_strobe),
      .address_write(address_write), .data_in(data_in), .read(read),
      .address_read(address_read), .data_out(dout_b), .read_valid(rvld_b),
      .collision(coll_b), .collision_count(cnt_b));

   register_file_byte_enable #(.BYPASS(0)) dut_n (
      .clock(clock), .reset(reset), .write(write), .write_strobe(write_strobe),
      .address_write(address_write), .data_in(data_in), .read(read),
      .address_read(address_read), .data_out(dout_n), .read_valid(rvld_n),
      .collision(coll_n), .collision_count(cnt_n));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      for (int i = 0; i < NW; i++) begin
         write[i] = 1'b0; write_strobe[i] = 2'b00; address_write[i] = '0; data_in[i] = '0;
      end
      for (int j = 0; j < NR; j++) begin
         read[j] = 1'b0; address_read[j] = '0;
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wr(input int p, input logic [4:0] a, input logic [1:0] s, input logic [15:0] d);
      write[p] = 1'b1; address_write[p] = a; write_strobe[p] = s; data_in[p] = d;
   endtask

   task automatic rd(input int p, input logic [4:0] a);
      read[p] = 1'b1; address_read[p] = a;
   endtask

   task automatic chk_reset_state(input string tag);
      for (int j = 0; j < NR; j++) begin
         chk($sformatf("%s_dout_b%0d", tag, j), dout_b[j], 16'h0000);
         chk($sformatf("%s_rvld_b%0d", tag, j), rvld_b[j], 1'b0);
         chk($sformatf("%s_dout_n%0d", tag, j), dout_n[j], 16'h0000);
         chk($sformatf("%s_rvld_n%0d", tag, j), rvld_n[j], 1'b0);
      end
      chk({tag, "_coll_b"}, coll_b, 1'b0);
      chk({tag, "_cnt_b"},  cnt_b,  16'd0);
      chk({tag, "_coll_n"}, coll_n, 1'b0);
      chk({tag, "_cnt_n"},  cnt_n,  16'd0);
   endtask

   initial begin
      reset = 1'b1;
      idle();
      tick();
      tick();
      chk_reset_state("por");
      reset = 1'b0;

      // Full write, then read on ports 0 and 7 at the same address.
      wr(0, 5'd3, 2'b11, 16'hA5C3);
      tick();
      idle();
      chk("full_wr_coll", coll_b, 1'b0);
      rd(0, 5'd3);
      rd(7, 5'd3);
      tick();
      idle();
      chk("full_rd_p0", dout_b[0], 16'hA5C3);
      chk("full_vld_p0", rvld_b[0], 1'b1);
      chk("full_rd_p7", dout_b[7], 16'hA5C3);
      chk("full_vld_p7", rvld_b[7], 1'b1);
      chk("idle_vld_p1", rvld_b[1], 1'b0);
      tick();
      chk("hold_vld_p0", rvld_b[0], 1'b0);
      chk("hold_dout_p0", dout_b[0], 16'hA5C3);

      // Partial write of the low byte only.
      wr(1, 5'd3, 2'b01, 16'h1234);
      tick();
      idle();
      rd(2, 5'd3);
      tick();
      idle();
      chk("partial_rd", dout_b[2], 16'hA534);

      // Full-overlap conflict; port 2 outranks port 0.
      wr(0, 5'd7, 2'b11, 16'h1111);
      wr(2, 5'd7, 2'b11, 16'h2222);
      tick();
      idle();
      chk("conf_coll", coll_b, 1'b1);
      chk("conf_cnt", cnt_b, 16'd1);
      rd(3, 5'd7);
      tick();
      idle();
      chk("conf_coll_drop", coll_b, 1'b0);
      chk("conf_cnt_hold", cnt_b, 16'd1);
      chk("conf_rd", dout_b[3], 16'h2222);

      // Disjoint strobes on one cell, plus a zero-strobe write that must be ignored.
      wr(0, 5'd9, 2'b10, 16'hAB00);
      wr(3, 5'd9, 2'b01, 16'h00CD);
      wr(1, 5'd9, 2'b00, 16'hFFFF);
      tick();
      idle();
      chk("split_coll", coll_b, 1'b0);
      chk("split_cnt", cnt_b, 16'd1);
      rd(4, 5'd9);
      tick();
      idle();
      chk("split_rd", dout_b[4], 16'hABCD);

      // Same-edge write and read: forwarded vs pre-write value.
      wr(0, 5'd5, 2'b11, 16'h0001);
      tick();
      idle();
      wr(0, 5'd5, 2'b11, 16'h00FF);
      rd(1, 5'd5);
      tick();
      idle();
      chk("byp1_rd", dout_b[1], 16'h00FF);
      chk("byp0_rd", dout_n[1], 16'h0001);
      rd(1, 5'd5);
      tick();
      idle();
      chk("byp0_after", dout_n[1], 16'h00FF);

      // Forwarding must honour per-byte priority of a partial-overlap conflict.
      wr(1, 5'd10, 2'b11, 16'h1111);
      wr(2, 5'd10, 2'b10, 16'h2200);
      rd(6, 5'd10);
      tick();
      idle();
      chk("byp_prio_rd", dout_b[6], 16'h2211);
      chk("byp_prio_coll", coll_b, 1'b1);
      chk("byp_prio_cnt", cnt_b, 16'd2);
      chk("nbyp_prio_cnt", cnt_n, 16'd2);
      rd(6, 5'd10);
      tick();
      idle();
      chk("nbyp_prio_rd", dout_n[6], 16'h2211);

      // Random traffic, then a one-cycle reset while traffic is still being driven.
      for (int c = 0; c < 21; c++) begin
         for (int i = 0; i < NW; i++) begin
            write[i]         = 1'b1;
            write_strobe[i]  = 2'($urandom_range(1, 3));
            address_write[i] = 5'($urandom_range(0, 31));
            data_in[i]       = 16'($urandom_range(1, 16'hFFFF));
         end
         for (int j = 0; j < NR; j++) begin
            read[j]         = 1'($urandom_range(0, 1));
            address_read[j] = 5'($urandom_range(0, 31));
         end
         if (c == 20) reset = 1'b1;
         tick();
      end
      reset = 1'b0;
      idle();
      chk_reset_state("mid");

      for (int a = 0; a < 32; a++) begin
         for (int j = 0; j < NR; j++) rd(j, 5'(a));
         tick();
         for (int j = 0; j < NR; j++) begin
            chk($sformatf("sweep_a%0d_p%0d", a, j), dout_b[j], 16'h0000);
            chk($sformatf("sweep_v%0d_p%0d", a, j), rvld_b[j], 1'b1);
            chk($sformatf("sweepn_a%0d_p%0d", a, j), dout_n[j], 16'h0000);
         end
      end
      idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
